gl_frac_diff: RTL and testbench
===============================

Name: gl_frac_diff

Overview:
- Grünwald-Letnikov fractional-order differentiator (order ALPHA, 0<ALPHA<1).
- Inverse operator of the windowed fractional integrator; sits on the same Q8.24 signal path as the integrator's counterpart.
- Each accepted sample triggers a serial multiply-accumulate of the last WIND samples against GL weights, using one MAC per cycle.
- Outputs one derivative sample per input, with a valid pulse and a toggle indicator.

Parameters:
- WIND, 32: window length (taps); must be a power of two.
- DW, 32: sample and coefficient width, signed Q8.24.
- FRAC, 24: fractional bits.
- ACC_W, 40: accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- Signal  in  DW  input sample, Q8.24 signed.
- in_valid  in  1  Signal is valid.
- in_ready  out  1  block can accept a sample.
- Output  out  DW  derivative sample, Q8.24 signed.
- out_valid  out  1  one-cycle pulse when Output is updated.
- OutInd  out  1  toggles on every Output update.

Behaviour:
- Reset (rst=0, async): all outputs are 0, including in_ready. Sample buffer is zeroed, wptr=0, accumulator=0, state=IDLE. in_ready rises on the first clock edge after rst releases.
- Buffer: circular, WIND×DW. Newest sample is at wptr. Tap k reads buf[(wptr−k) mod WIND]; wrap-around is natural modulo WIND.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, write buf[wptr+1]←Signal, advance wptr, clear acc, set k=0, go to MAC.
  - MAC: in_ready=0. Each cycle: acc += sext(prod[55:24]), where prod = buf[wptr−k]×coef[k] (64-bit signed), then k++. After k=WIND−1, go to DONE. Exactly WIND cycles.
  - DONE: Output←fmt(acc), out_valid=1 for this one cycle, OutInd toggles, go to IDLE.
- Latency: accept edge T → Output/out_valid at edge T+WIND+1.
- Throughput: one sample per WIND+2 cycles.
- in_valid while busy: ignored. Upstream holds the sample until in_ready=1, so the buffer is never written during MAC.
- Initial fill: unwritten slots read as 0, so the first outputs are partial sums.
- Rounding: truncation (arithmetic shift) of prod to Q8.24 before accumulation.
- Reset mid-MAC: the computation is aborted, no out_valid is issued, and the buffer is cleared.
- Coefficients: w0=1.0, wk=w(k−1)·(1−(ALPHA+1)/k). Stored Q8.24, sample step h=1; h^−ALPHA scaling is applied downstream.

Optional Feature:
- Macro: GL_FRAC_DIFF_SAT_EN.
- Defined: Output saturates acc to [−2^31, 2^31−1].
- Undefined: Output = acc[31:0] (two's-complement wrap).
- Either way, accumulator width and latency are unchanged.

Decomposition:
- Shared package frac_pkg:
  - Q8.24 typedef, FRAC constant, Q_ONE=16777216.
  - Saturation function.
  - Default WIND.
  - These are also consumed by the integrator path.
- Sub-module gl_coeff_rom: combinational lookup k→coef[k] for ALPHA=0.5.
  - First entries: 16777216, −8388608, −2097152, −1048576, −655360, …
  - ROM values are generated offline.

Test Plan:
- Reset: assert rst=0 mid-MAC → out_valid stays 0, Output=0, OutInd=0. After release, the next output uses the zeroed buffer.
- Impulse: Signal=16777216, then zeros, each accepted when in_ready → Outputs 16777216, −8388608, −2097152, −1048576, −655360.
- Step: Signal=16777216 held for 4 accepts → Outputs 16777216, 8388608, 6291456, 5242880.
- Timing: accept at edge T → out_valid exactly at T+33 (WIND=32). in_ready low T+1..T+33. OutInd flips once per output.
- Wrap: feed 40 samples of 16777216 → the 33rd and later outputs are constant (full-window sum), with no stale-pointer glitch at the wrap.
- Overflow: Signal=0x7FFFFFFF alternating with 0x80000000 for a full window → 0x7FFFFFFF or 0x80000000 with SAT_EN, wrapped acc[31:0] without it.

Source files
------------

// File: rtl/frac_pkg.sv
// -----------------------------------------------------------------------------
// frac_pkg
// Shared definitions for the Q8.24 fractional-calculus signal path. Both the
// Grunwald-Letnikov differentiator and the windowed integrator use it.
//   q8_24_t    : signed Q8.24 sample/coefficient type
//   FRAC_BITS  : number of fractional bits (24)
//   Q_ONE      : 1.0 in Q8.24
//   WIND_DEF   : default window length (taps)
//   gl_state_e : sequencing states of the differentiator
//   sat_q()    : clamp a wide signed value to the Q8.24 range
// -----------------------------------------------------------------------------
package frac_pkg;

    localparam int Q_W       = 32;
    localparam int FRAC_BITS = 24;
    localparam int WIND_DEF  = 32;
    localparam int SAT_IN_W  = 64;

    typedef logic signed [Q_W-1:0] q8_24_t;

    localparam q8_24_t Q_ONE = 32'sd16777216;

    localparam logic signed [SAT_IN_W-1:0] Q_MAX_W = 64'sd2147483647;
    localparam logic signed [SAT_IN_W-1:0] Q_MIN_W = -64'sd2147483648;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } gl_state_e;

    // Clamp to [-2^31, 2^31-1]; callers sign-extend their accumulator first.
    function automatic q8_24_t sat_q(input logic signed [SAT_IN_W-1:0] a);
        if (a > Q_MAX_W)
            return 32'sh7FFF_FFFF;
        else if (a < Q_MIN_W)
            return 32'sh8000_0000;
        else
            return a[Q_W-1:0];
    endfunction

endpackage

// File: rtl/gl_coeff_rom.sv
// -----------------------------------------------------------------------------
// gl_coeff_rom
// Combinational Grunwald-Letnikov weight table for ALPHA = 0.5, Q8.24.
// w0 = 1.0, wk = w(k-1) * (1 - (ALPHA+1)/k), magnitudes rounded to nearest
// (ties away from zero). Table was generated offline and holds 32 taps.
// Ports:
//   i_k    in  AW  tap index
//   o_coef out 32  weight for tap i_k, Q8.24 signed
// -----------------------------------------------------------------------------
module gl_coeff_rom
    import frac_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_k,
    output q8_24_t        o_coef
);

    logic [4:0] w_idx;

    assign w_idx = 5'(i_k);

    always_comb begin
        o_coef = '0;
        case (w_idx)
            5'd0:  o_coef = Q_ONE;
            5'd1:  o_coef = -32'sd8388608;
            5'd2:  o_coef = -32'sd2097152;
            5'd3:  o_coef = -32'sd1048576;
            5'd4:  o_coef = -32'sd655360;
            5'd5:  o_coef = -32'sd458752;
            5'd6:  o_coef = -32'sd344064;
            5'd7:  o_coef = -32'sd270336;
            5'd8:  o_coef = -32'sd219648;
            5'd9:  o_coef = -32'sd183040;
            5'd10: o_coef = -32'sd155584;
            5'd11: o_coef = -32'sd134368;
            5'd12: o_coef = -32'sd117572;
            5'd13: o_coef = -32'sd104006;
            5'd14: o_coef = -32'sd92863;
            5'd15: o_coef = -32'sd83576;
            5'd16: o_coef = -32'sd75741;
            5'd17: o_coef = -32'sd69058;
            5'd18: o_coef = -32'sd63303;
            5'd19: o_coef = -32'sd58306;
            5'd20: o_coef = -32'sd53933;
            5'd21: o_coef = -32'sd50080;
            5'd22: o_coef = -32'sd46666;
            5'd23: o_coef = -32'sd43622;
            5'd24: o_coef = -32'sd40896;
            5'd25: o_coef = -32'sd38442;
            5'd26: o_coef = -32'sd36224;
            5'd27: o_coef = -32'sd34212;
            5'd28: o_coef = -32'sd32379;
            5'd29: o_coef = -32'sd30704;
            5'd30: o_coef = -32'sd29169;
            5'd31: o_coef = -32'sd27758;
            default: o_coef = '0;
        endcase
    end

endmodule

// File: rtl/gl_frac_diff.sv
// -----------------------------------------------------------------------------
// gl_frac_diff
// Grunwald-Letnikov fractional differentiator (ALPHA = 0.5), Q8.24 path.
// Each accepted sample is written to a circular window buffer, then WIND
// serial MAC cycles sum buf[wptr-k]*coef[k] (k = 0..WIND-1), then the result
// is registered onto Output with a one-cycle out_valid and an OutInd toggle.
// Accept at edge T -> out_valid at edge T+WIND+1; one sample per WIND+2 cycles.
// Optional build macro GL_FRAC_DIFF_SAT_EN: saturate Output to the Q8.24 range
// instead of wrapping the low 32 accumulator bits.
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-low reset
//   Signal    in   DW  input sample, Q8.24 signed
//   in_valid  in   1   Signal is valid
//   in_ready  out  1   block can accept a sample (registered, low in reset)
//   Output    out  DW  derivative sample, Q8.24 signed
//   out_valid out  1   one-cycle pulse when Output updates
//   OutInd    out  1   toggles on every Output update
// -----------------------------------------------------------------------------
module gl_frac_diff
    import frac_pkg::*;
#(
    parameter int WIND  = WIND_DEF,
    parameter int DW    = 32,
    parameter int FRAC  = FRAC_BITS,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] Signal,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] Output,
    output logic                 out_valid,
    output logic                 OutInd
);

    localparam int AW = $clog2(WIND);
    localparam int PW = DW + Q_W;

    gl_state_e r_state, w_state_nxt;

    logic signed [DW-1:0]    r_buf [WIND];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_k;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_in_ready;
    logic signed [DW-1:0]    r_out;
    logic                    r_out_valid;
    logic                    r_ind;

    logic                    w_accept;
    logic                    w_mac_en;
    logic                    w_done;
    logic                    w_ready_nxt;
    logic [AW-1:0]           w_wr_addr;
    logic [AW-1:0]           w_rd_addr;
    q8_24_t                  w_coef;
    logic signed [PW-1:0]    w_prod;
    logic signed [DW-1:0]    w_term;
    logic signed [DW-1:0]    w_fmt;
    logic                    w_unused;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                   w_state_nxt = ST_MAC;
            ST_MAC:  if (r_k == AW'(WIND - 1))       w_state_nxt = ST_DONE;
            ST_DONE:                                 w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && in_valid && r_in_ready;
        w_mac_en    = (r_state == ST_MAC);
        w_done      = (r_state == ST_DONE);
        // in_ready is registered so it stays low through reset and rises one
        // edge after release.
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // ---------------- datapath ----------------
    assign w_wr_addr = r_wptr + AW'(1);
    assign w_rd_addr = r_wptr - r_k;   // modulo WIND by pointer width

    gl_coeff_rom #(.AW(AW)) u_rom (
        .i_k    (r_k),
        .o_coef (w_coef)
    );

    assign w_prod = PW'(r_buf[w_rd_addr]) * PW'(w_coef);
    // Truncate the Q16.48 product back to Q8.24 (arithmetic shift).
    assign w_term = w_prod[FRAC+DW-1:FRAC];
    assign w_unused = ^{w_prod[PW-1:FRAC+DW], w_prod[FRAC-1:0]};

`ifdef GL_FRAC_DIFF_SAT_EN
    assign w_fmt = DW'(sat_q(SAT_IN_W'(r_acc)));
`else
    assign w_fmt = r_acc[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIND; i++) r_buf[i] <= '0;
            r_wptr      <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ind       <= 1'b0;
        end else begin
            r_in_ready  <= w_ready_nxt;
            r_out_valid <= w_done;
            if (w_accept) begin
                r_buf[w_wr_addr] <= Signal;
                r_wptr           <= w_wr_addr;
                r_acc            <= '0;
                r_k              <= '0;
            end
            if (w_mac_en) begin
                r_acc <= r_acc + ACC_W'(w_term);
                r_k   <= r_k + AW'(1);
            end
            if (w_done) begin
                r_out <= w_fmt;
                r_ind <= ~r_ind;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign Output    = r_out;
    assign out_valid = r_out_valid;
    assign OutInd    = r_ind;

endmodule

// File: tb/tb_gl_frac_diff.sv
`timescale 1ns/1ps
module tb_gl_frac_diff;

    localparam int WIND = 32;
    localparam int LAT  = WIND + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] Signal = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] Output;
    logic               out_valid;
    logic               OutInd;

    always #5 clk = ~clk;

    gl_frac_diff #(.WIND(WIND), .DW(32), .FRAC(24), .ACC_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .Signal    (Signal),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Output    (Output),
        .out_valid (out_valid),
        .OutInd    (OutInd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cf[WIND];     // GL weights from the recurrence, Q8.24
    int hist[$];      // newest sample first
    bit exp_ind = 1'b0;
    int last_out;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_coefs();
        real w;
        w = 16777216.0;
        cf[0] = 16777216;
        for (int k = 1; k < WIND; k++) begin
            // (1 - 1.5/k) == (2k-3)/(2k)
            w = w * real'(2 * k - 3) / real'(2 * k);
            cf[k] = (w < 0.0) ? -$rtoi(-w + 0.5) : $rtoi(w + 0.5);
        end
    endfunction

    function automatic int model_out();
        longint acc;
        longint lim;
        acc = 0;
        lim = 64'sd2147483648;
        for (int k = 0; k < hist.size(); k++) begin
            longint p;
            p = longint'(hist[k]) * longint'(cf[k]);
            acc += longint'(int'(p >>> 24));
        end
`ifdef GL_FRAC_DIFF_SAT_EN
        if (acc > lim - 1) return int'(lim - 1);
        if (acc < -lim)    return int'(-lim);
`endif
        return int'(acc);
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        hist.delete();
        exp_ind = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    // Offer one sample, wait for its result, check timing/flags/value.
    task automatic xfer(input int s, input bit use_exp, input int exp_v, input string nm);
        int n, t0, busy_hi, want;
        Signal = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin
            chk({nm, "_ready_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        tick();                       // accept edge
        t0 = cyc;
        in_valid = 1'b0;
        Signal = $urandom;            // must not matter once accepted
        hist.push_front(s);
        if (hist.size() > WIND) void'(hist.pop_back());
        want = use_exp ? exp_v : model_out();
        n = 0;
        busy_hi = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_hi++;
            tick();
            n++;
        end
        chk({nm, "_busy_ready"}, busy_hi, 0);
        if (!out_valid) begin
            chk({nm, "_out_timeout"}, 0, 1);
            return;
        end
        chk({nm, "_latency"}, cyc - t0, LAT);
        chk({nm, "_value"}, Output, want);
        exp_ind = ~exp_ind;
        chk({nm, "_ind"}, OutInd, exp_ind);
        chk({nm, "_ready_after"}, in_ready, 1);
        last_out = Output;
        tick();
        chk({nm, "_pulse"}, out_valid, 0);
    endtask

    typedef struct {
        bit rst_before;
        int sig;
        int exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, bad;
        build_coefs();
        tbl[0] = '{1'b1, 16777216, 16777216};
        tbl[1] = '{1'b0, 0, -8388608};
        tbl[2] = '{1'b0, 0, -2097152};
        tbl[3] = '{1'b0, 0, -1048576};
        tbl[4] = '{1'b0, 0, -655360};
        tbl[5] = '{1'b1, 16777216, 16777216};
        tbl[6] = '{1'b0, 16777216, 8388608};
        tbl[7] = '{1'b0, 16777216, 6291456};
        tbl[8] = '{1'b0, 16777216, 5242880};

        // reset state
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_output", Output, 0);
        chk("rst_ind", OutInd, 0);
        rst = 1'b1;
        tick();
        chk("ready_after_release", in_ready, 1);

        // impulse and step vectors
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            xfer(tbl[i].sig, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // reset mid-MAC: abort, clear outputs and buffer
        xfer(32'h0123_4567, 1'b0, 0, "pre_rst");
        Signal = 32'h0200_0000;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_output", Output, 0);
        chk("midrst_ind", OutInd, 0);
        chk("midrst_ready", in_ready, 0);
        bad = 0;
        repeat (40) begin
            tick();
            if (out_valid || Output != 0) bad++;
        end
        chk("midrst_quiet", bad, 0);
        hist.delete();
        exp_ind = 1'b0;
        rst = 1'b1;
        tick();
        xfer(32'h0300_0000, 1'b1, 32'h0300_0000, "post_rst0");
        xfer(32'h0100_0000, 1'b0, 0, "post_rst1");

        // wrap: constant input, full-window sum must hold past the wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int prev;
            prev = last_out;
            xfer(16777216, 1'b0, 0, $sformatf("wrap%0d", i));
            if (i >= WIND) chk($sformatf("wrap_const%0d", i), last_out, prev);
        end

        // overflow: alternating rails
        do_reset();
        for (int i = 0; i < 36; i++)
            xfer((i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 0,
                 $sformatf("ovf%0d", i));

        // randomized samples with idle gaps
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                            : int'($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000;
            repeat ($urandom_range(0, 3)) tick();
            xfer(s, 1'b0, 0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
